// File: rtl/tx_block_scheduler_pkg.sv
// Shared transmit-path types: scheduler states, source selects and the default
// transport-block geometry that the shaper instantiation also uses.
package tx_block_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SEND,
        PAD,
        GAP
    } tx_state_e;

    localparam logic SRC_USR  = 1'b0;
    localparam logic SRC_PRBS = 1'b1;

    localparam int TB_BYTES_DEF = 476;
    localparam int GAP_CYC_DEF  = 16;

endpackage

// File: rtl/tx_blk_src_mux.sv
// Combinational byte-source mux: steers the shaper ready back to the active
// source in SEND and substitutes zero pad bytes in PAD.
module tx_blk_src_mux
    import tx_block_scheduler_pkg::*;
(
    input  tx_state_e   i_state,
    input  logic        i_src,
    input  logic [7:0]  i_usr_tdata,
    input  logic        i_usr_tvalid,
    input  logic [7:0]  i_prbs_dat,
    input  logic        i_prbs_val,
    input  logic        i_ireq,
    output logic [7:0]  o_odata,
    output logic        o_oval,
    output logic        o_usr_tready,
    output logic        o_prbs_req
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_odata      = 8'h00;
        o_oval       = 1'b0;
        o_usr_tready = 1'b0;
        o_prbs_req   = 1'b0;
        case (i_state)
            SEND: begin
                if (i_src == SRC_PRBS) begin
                    o_oval     = i_prbs_val;
                    o_odata    = i_prbs_dat;
                    o_prbs_req = i_ireq;
                end else begin
                    o_oval       = i_usr_tvalid;
                    o_odata      = i_usr_tdata;
                    o_usr_tready = i_ireq;
                end
            end
            PAD:     o_oval = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/tx_block_scheduler.sv
// Transport-block scheduler: frames user/PRBS bytes into fixed-length blocks,
// pads or splits user packets, and holds PHY config stable across each block.
module tx_block_scheduler
    import tx_block_scheduler_pkg::*;
#(
    parameter int TB_BYTES = TB_BYTES_DEF,
    parameter int GAP_CYC  = GAP_CYC_DEF,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_en,
    input  logic             cfg_src_sel,
    input  logic [3:0]       cfg_ss_in,
    input  logic [2:0]       cfg_m_in,
    input  logic [2:0]       cfg_bw_in,
    input  logic [7:0]       usr_tdata,
    input  logic             usr_tvalid,
    input  logic             usr_tlast,
    output logic             usr_tready,
    input  logic [7:0]       prbs_dat,
    input  logic             prbs_val,
    output logic             prbs_req,
    output logic [7:0]       odata,
    output logic             oval,
    input  logic             ireq,
    output logic             osop,
    output logic             oeop,
    output logic [3:0]       ss_out,
    output logic [2:0]       m_out,
    output logic [2:0]       bw_out,
    output logic             data_off,
    output logic [CNT_W-1:0] blk_cnt
);

    localparam int BC_W = $clog2(TB_BYTES);
    localparam int GC_W = $clog2(GAP_CYC + 1);
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(TB_BYTES - 1);
    localparam logic [GC_W-1:0] GAP_LAST  = GC_W'(GAP_CYC - 1);

    tx_state_e        r_state;
    tx_state_e        w_state_nxt;
    logic             r_src_q;
    logic [BC_W-1:0]  r_byte_cnt;
    logic [GC_W-1:0]  r_gap_cnt;
    logic [CNT_W-1:0] r_blk_cnt;
    logic [3:0]       r_ss;
    logic [2:0]       r_m;
    logic [2:0]       r_bw;

    logic w_xfer;
    logic w_last_byte;
    logic w_gap_done;
    logic w_in_block;

    tx_blk_src_mux u_src_mux (
        .i_state      (r_state),
        .i_src        (r_src_q),
        .i_usr_tdata  (usr_tdata),
        .i_usr_tvalid (usr_tvalid),
        .i_prbs_dat   (prbs_dat),
        .i_prbs_val   (prbs_val),
        .i_ireq       (ireq),
        .o_odata      (odata),
        .o_oval       (oval),
        .o_usr_tready (usr_tready),
        .o_prbs_req   (prbs_req)
    );

    assign w_in_block  = (r_state == SEND) || (r_state == PAD);
    assign w_xfer      = oval && ireq;
    assign w_last_byte = (r_byte_cnt == LAST_BYTE);
    assign w_gap_done  = (r_gap_cnt == GAP_LAST);

    // The byte counter is zero outside a block and oval is low there, so these
    // need no explicit state qualification.
    assign osop     = oval && (r_byte_cnt == '0);
    assign oeop     = oval && w_last_byte;
    assign data_off = !w_in_block;
    assign ss_out   = r_ss;
    assign m_out    = r_m;
    assign bw_out   = r_bw;
    assign blk_cnt  = r_blk_cnt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (cfg_en) w_state_nxt = ARM;
            ARM:  w_state_nxt = SEND;
            SEND: begin
                if (w_xfer) begin
                    if (w_last_byte)
                        w_state_nxt = GAP;
                    else if ((r_src_q == SRC_USR) && usr_tlast)
                        w_state_nxt = PAD;
                end
            end
            PAD:  if (w_xfer && w_last_byte) w_state_nxt = GAP;
            GAP:  if (w_gap_done) w_state_nxt = cfg_en ? ARM : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_src_q    <= SRC_USR;
            r_byte_cnt <= '0;
            r_gap_cnt  <= '0;
            r_blk_cnt  <= '0;
            r_ss       <= '0;
            r_m        <= '0;
            r_bw       <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == ARM) begin
                r_src_q    <= cfg_src_sel;
                r_ss       <= cfg_ss_in;
                r_m        <= cfg_m_in;
                r_bw       <= cfg_bw_in;
                r_byte_cnt <= '0;
            end else if (w_in_block && w_xfer) begin
                r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + 1'b1;
            end

            if (r_state == GAP)
                r_gap_cnt <= r_gap_cnt + 1'b1;
            else
                r_gap_cnt <= '0;

            // Counted on GAP entry so an abandoned (reset) block never counts.
            if ((w_state_nxt == GAP) && (r_state != GAP))
                r_blk_cnt <= r_blk_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_tx_block_scheduler.sv
// Scoreboard bench for tx_block_scheduler: expected block bytes are queued from
// the stimulus and compared on every shaper transfer.
module tb_tx_block_scheduler;
    import tx_block_scheduler_pkg::*;

    localparam int TB  = 476;
    localparam int GAP = 16;
    localparam int CW  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          cfg_en;
    logic          cfg_src_sel;
    logic [3:0]    cfg_ss_in;
    logic [2:0]    cfg_m_in;
    logic [2:0]    cfg_bw_in;
    logic [7:0]    usr_tdata;
    logic          usr_tvalid;
    logic          usr_tlast;
    logic          usr_tready;
    logic [7:0]    prbs_dat;
    logic          prbs_val;
    logic          prbs_req;
    logic [7:0]    odata;
    logic          oval;
    logic          ireq;
    logic          osop;
    logic          oeop;
    logic [3:0]    ss_out;
    logic [2:0]    m_out;
    logic [2:0]    bw_out;
    logic          data_off;
    logic [CW-1:0] blk_cnt;

    tx_block_scheduler #(.TB_BYTES(TB), .GAP_CYC(GAP), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_src_sel(cfg_src_sel),
        .cfg_ss_in(cfg_ss_in), .cfg_m_in(cfg_m_in), .cfg_bw_in(cfg_bw_in),
        .usr_tdata(usr_tdata), .usr_tvalid(usr_tvalid), .usr_tlast(usr_tlast),
        .usr_tready(usr_tready), .prbs_dat(prbs_dat), .prbs_val(prbs_val),
        .prbs_req(prbs_req), .odata(odata), .oval(oval), .ireq(ireq),
        .osop(osop), .oeop(oeop), .ss_out(ss_out), .m_out(m_out),
        .bw_out(bw_out), .data_off(data_off), .blk_cnt(blk_cnt)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } usr_beat_t;

    // Expected transfer word: {data_off, osop, oeop, usr_tready, prbs_req, odata}
    usr_beat_t   usr_q[$];
    logic [12:0] exp_q[$];

    int n_checks = 0;
    int n_err    = 0;
    int cyc = 0, xfer_cnt = 0, sop_cnt = 0, gap_left = 0, mark = 0, next_lat = -1;
    int en_drop_sop = 1, m_chg_at = -1, p_idx = 0, prbs_base = 0, exp_blk = 0;
    bit sb_en = 0, lat_on = 0, mirror_chk = 0, toggle_ireq = 0, usr_gaps = 0;
    bit pop_usr, pop_prbs;
    logic [9:0] exp_cfg;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] prbs_byte(input int idx);
        logic [31:0] h;
        h = 32'(idx) * 32'h9E37_79B1;
        return h[31:24] ^ h[15:8];
    endfunction

    task automatic drive_inputs();
        usr_tvalid = (usr_q.size() != 0) && (!usr_gaps || ($urandom_range(0, 3) != 0));
        usr_tdata  = 8'h00;
        usr_tlast  = 1'b0;
        if (usr_q.size() != 0) begin
            usr_tdata = usr_q[0].data;
            usr_tlast = usr_q[0].last;
        end
        prbs_dat = prbs_byte(p_idx);
        prbs_val = 1'b1;
        ireq     = toggle_ireq ? ~ireq : 1'b1;
        if (sop_cnt >= en_drop_sop) cfg_en = 1'b0;
        if (xfer_cnt == m_chg_at) begin
            cfg_m_in = 3'd4;
            cfg_en   = 1'b0;
        end
    endtask

    task automatic push_prbs_block();
        for (int k = 0; k < TB; k++)
            exp_q.push_back({1'b0, (k == 0), (k == TB - 1), 1'b0, 1'b1, prbs_byte(prbs_base + k)});
        prbs_base += TB;
    endtask

    task automatic push_user(input int len);
        usr_beat_t b;
        logic [7:0] d;
        int k;
        for (int i = 0; i < len; i++) begin
            d = 8'($urandom_range(0, 255));
            b.data = d;
            b.last = (i == len - 1);
            usr_q.push_back(b);
            k = i % TB;
            exp_q.push_back({1'b0, (k == 0), (k == TB - 1), 1'b1, 1'b0, d});
        end
        for (int i = len; (i % TB) != 0; i++)
            exp_q.push_back({1'b0, 1'b0, ((i % TB) == TB - 1), 1'b0, 1'b0, 8'h00});
    endtask

    task automatic step();
        logic [12:0] got;
        logic [12:0] e;
        @(negedge clk);
        cyc++;
        pop_usr  = usr_tvalid && usr_tready;
        pop_prbs = prbs_val && prbs_req;
        if (sb_en) begin
            if (mirror_chk && oval) check("prbs_req_mirror", 32'(prbs_req), 32'(ireq));
            if (gap_left > 0) begin
                if (gap_left == GAP) check("blk_cnt", 32'(blk_cnt), 32'(exp_blk));
                check("gap_off", 32'({data_off, oval}), 32'(2'b10));
                gap_left--;
            end else if (exp_q.size() == 0) begin
                check("idle_off", 32'({data_off, oval}), 32'(2'b10));
            end else if (oval && ireq) begin
                got = {data_off, osop, oeop, usr_tready, prbs_req, odata};
                e   = exp_q.pop_front();
                xfer_cnt++;
                check($sformatf("byte%0d", xfer_cnt), 32'(got), 32'(e));
                if (e[11]) begin
                    sop_cnt++;
                    if (next_lat >= 0) check("sop_latency", 32'(cyc - mark), 32'(next_lat));
                end
                if (e[10]) begin
                    check("cfg_latch", 32'({ss_out, m_out, bw_out}), 32'(exp_cfg));
                    exp_blk++;
                    gap_left = GAP;
                    mark     = cyc;
                    next_lat = (lat_on && cfg_en) ? GAP + 2 : -1;
                end
            end
        end
        @(posedge clk);
        #1;
        if (pop_usr) void'(usr_q.pop_front());
        if (pop_prbs) p_idx++;
        drive_inputs();
    endtask

    task automatic run_block(input int max_cyc);
        for (int n = 0; n < max_cyc && (exp_q.size() != 0 || gap_left != 0); n++) step();
        check("drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        usr_q.delete();
    endtask

    task automatic start_block(input int lat);
        xfer_cnt = 0;
        sop_cnt  = 0;
        cfg_en   = 1'b1;
        mark     = cyc;
        next_lat = lat;
        drive_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lens[3];
        lens = '{100, TB, 1};
        rst = 1'b0; cfg_en = 1'b0; cfg_src_sel = 1'b0;
        cfg_ss_in = '0; cfg_m_in = '0; cfg_bw_in = '0; ireq = 1'b1;
        drive_inputs();

        // 1: reset state
        repeat (3) step();
        check("rst_outs", 32'({data_off, oval, osop, oeop, usr_tready, prbs_req}), 32'(6'b100000));
        check("rst_blk", 32'(blk_cnt), 32'd0);
        check("rst_cfg", 32'({ss_out, m_out, bw_out}), 32'd0);
        rst = 1'b1;
        sb_en = 1'b1;
        repeat (3) step();

        // 2: two back-to-back PRBS blocks, ss=5
        cfg_src_sel = SRC_PRBS; cfg_ss_in = 4'd5; cfg_m_in = 3'd3; cfg_bw_in = 3'd2;
        exp_cfg = {4'd5, 3'd3, 3'd2};
        lat_on = 1'b1; en_drop_sop = 2;
        push_prbs_block();
        push_prbs_block();
        start_block(3);
        run_block(3000);
        repeat (3) step();

        // 3: short user packet padded, exact-length packet, single-byte packet
        cfg_src_sel = SRC_USR; cfg_ss_in = 4'd7; cfg_m_in = 3'd1; cfg_bw_in = 3'd5;
        exp_cfg = {4'd7, 3'd1, 3'd5};
        en_drop_sop = 1;
        foreach (lens[i]) begin
            push_user(lens[i]);
            start_block(3);
            run_block(2000);
            repeat (3) step();
        end

        // 4: 600-byte packet split over two blocks, bursty tvalid
        cfg_ss_in = 4'd12; cfg_m_in = 3'd6; cfg_bw_in = 3'd0;
        exp_cfg = {4'd12, 3'd6, 3'd0};
        lat_on = 1'b0; usr_gaps = 1'b1; en_drop_sop = 2;
        push_user(600);
        start_block(-1);
        run_block(5000);
        usr_gaps = 1'b0;
        repeat (3) step();

        // 5: cfg change and cfg_en drop mid-block
        cfg_src_sel = SRC_PRBS; cfg_ss_in = 4'd3; cfg_m_in = 3'd2; cfg_bw_in = 3'd1;
        exp_cfg = {4'd3, 3'd2, 3'd1};
        lat_on = 1'b1; en_drop_sop = 99; m_chg_at = 200;
        push_prbs_block();
        start_block(3);
        run_block(2000);
        m_chg_at = -1;
        repeat (5) step();
        check("m_hold", 32'(m_out), 32'd2);

        // 6: ireq toggling, then reset 300 bytes into the second block
        cfg_ss_in = 4'd9; cfg_m_in = 3'd1; cfg_bw_in = 3'd6;
        exp_cfg = {4'd9, 3'd1, 3'd6};
        lat_on = 1'b0; en_drop_sop = 2; toggle_ireq = 1'b1; mirror_chk = 1'b1;
        push_prbs_block();
        push_prbs_block();
        start_block(-1);
        for (int n = 0; n < 5000 && xfer_cnt < TB + 300; n++) step();
        check("xfers_before_rst", 32'(xfer_cnt), 32'(TB + 300));
        check("pre_rst_blk", 32'(blk_cnt), 32'(exp_blk));
        sb_en = 1'b0;
        exp_q.delete();
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("mid_rst_outs", 32'({data_off, oval, osop, oeop, usr_tready, prbs_req}), 32'(6'b100000));
        check("mid_rst_blk", 32'(blk_cnt), 32'd0);
        toggle_ireq = 1'b0; mirror_chk = 1'b0; gap_left = 0;
        sb_en = 1'b1;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
